pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch stage directly upstream of the IF/ID pipeline register. Holds the program counter, drives the instruction-memory address, and hands the fetched instruction and its PC to IF/ID. Resolves the next PC from branch redirects, call targets and returns. Returns are popped from an internal return-address stack (RAS). A decoded halt freezes fetch.

## Interface

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- data_hazard  in  1  hold PC (load-use stall)
- PC_hazard  in  1  taken-branch redirect from later stage
- branch_target  in  16  redirect address, valid with PC_hazard
- call  in  1  call decoded in ID (single-cycle pulse)
- call_target  in  12  Inst[11:0] of the call
- call_PC  in  16  PC of the call instruction
- ret_control  in  1  return decoded in ID (single-cycle pulse)
- halt  in  1  halt decoded in ID
- imem_instr  in  16  instruction memory read data (combinational from imem_addr)
- imem_addr  out  16  instruction memory address
- PC_out  out  16  PC of the fetched instruction, to IF/ID PC_in
- instruction_out  out  16  fetched instruction, to IF/ID instruction_in
- ret_PC  out  1  return redirect taken, one-cycle pulse, to IF/ID
- halted  out  1  fetch frozen
- ras_overflow  out  1  sticky, push while RAS full
- ras_underflow  out  1  sticky, pop while RAS empty

## Operation

- FSM states: RUN, RET, HALT. Reset → RUN.
- Next-PC priority, evaluated each edge in RUN or RET:
  1. PC_hazard → branch_target
  2. call → {call_PC[15:12], call_target}; push call_PC+1
  3. ret_control → popped RAS entry; state → RET
  4. data_hazard → hold
  5. otherwise PC+1
- PC+1 and call_PC+1 are 16-bit modulo (16'hFFFF+1 = 16'h0000).
- Simultaneous call and ret_control: call wins; the ret is dropped and there is no pop.
- RET lasts exactly one cycle, then → RUN. ret_control arriving while in RET is ignored. Other priority items apply normally in RET.
- halt (any state except during rst) → HALT. HALT is absorbing until rst. In HALT the PC is held, all inputs are ignored, and instruction_out = 16'hF000.
- RAS is circular with pointer sp and occupancy count.
  - Push when full: overwrite the oldest entry, count stays RAS_DEPTH, set ras_overflow.
  - Pop when empty: set ras_underflow, → HALT, PC held.
- Reset values: PC = RESET_PC, state RUN, sp = 0, count = 0, ras_overflow = 0, ras_underflow = 0, ret_PC = 0, halted = 0. RAS contents are don't-care.
- Reset mid-RET or in HALT returns to RUN with the reset values above.

## Timing

- imem_addr = PC_out = PC register (no combinational input path).
- instruction_out = imem_instr in RUN/RET (combinational pass-through), 16'hF000 in HALT.
- Redirect latency: an input sampled at edge N makes the new PC visible after edge N. The instruction wrongly fetched in the cycle of the request is squashed by IF/ID, not by this block.
- ret_PC = (state == RET), asserted the cycle after the ret_control edge, for one cycle.
- halted = (state == HALT), registered.
- data_hazard alone causes no pop or push and holds the PC for every cycle it is high.

## Structure

- Shared package cpu_pkg:
  - NO_OP = 16'hF000
  - fetch_state_t enum {RUN, RET, HALT}
  - PC_W = 16
- Sub-module return_addr_stack (params DEPTH, W):
  - inputs push, pop, push_data
  - outputs top, full, empty, overflow_evt, underflow_evt
  - same clk and rst
- pc_fetch_unit contains the PC register, next-PC priority mux, FSM and sticky flags.

## Test plan

- Reset with RESET_PC = 16'h0000, then free run 3 cycles → PC_out 0000, 0001, 0002, 0003. ret_PC = halted = 0.
- PC = 16'h0010, data_hazard high 2 cycles → PC_out holds 0010 for both cycles, then 0011.
- call with call_PC = 16'h1234, call_target = 12'h0AB → PC = 16'h10AB. Later a ret_control pulse → PC = 16'h1235, ret_PC high exactly one cycle.
- Same cycle PC_hazard (branch_target = 16'h0200) and call → PC = 16'h0200 with no RAS push. A subsequent ret_control underflows → ras_underflow = 1, halted = 1, instruction_out = 16'hF000.
- Five nested calls (DEPTH 4) with return addresses A1..A5 → ras_overflow = 1. Five rets → A5, A4, A3, A2, then the fifth ret underflows into HALT.
- Wrap and halt: PC = 16'hFFFF free run → 16'h0000. halt pulse → PC frozen and halted = 1 until rst. rst in HALT → PC = RESET_PC, flags cleared.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC width, halt-time filler instruction, fetch FSM states.
package cpu_pkg;

  localparam int unsigned PC_W = 16;

  localparam logic [PC_W-1:0] NO_OP = 16'hF000;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    RET  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack with a write pointer and occupancy count.
// Ports: push/push_data write the entry at sp; pop removes the entry below sp;
//        top is that entry; full/empty from the count; *_evt flag a push while
//        full (oldest entry overwritten) or a pop while empty (ignored).
module return_addr_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         overflow_evt,
  output logic         underflow_evt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_sp;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_top_idx;

  // sp points at the next free slot; when full it also points at the oldest entry
  assign w_top_idx     = PTR_W'(r_sp - PTR_W'(1));
  assign top           = r_mem[w_top_idx];
  assign full          = (r_count == CNT_W'(DEPTH));
  assign empty         = (r_count == CNT_W'(0));
  assign overflow_evt  = push & full;
  assign underflow_evt = pop & ~push & empty;

  // Pointer and occupancy; push takes precedence over pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (push) begin
      r_sp <= PTR_W'(r_sp + PTR_W'(1));
      if (!full) r_count <= CNT_W'(r_count + CNT_W'(1));
    end else if (pop && !empty) begin
      r_sp    <= w_top_idx;
      r_count <= CNT_W'(r_count - CNT_W'(1));
    end
  end

  // Storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) r_mem[r_sp] <= push_data;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC priority mux, RUN/RET/HALT FSM,
// return-address stack and sticky RAS error flags.
// Ports: redirect inputs (PC_hazard/branch_target, call/call_target/call_PC,
//        ret_control, data_hazard, halt); imem_addr/imem_instr to instruction
//        memory; PC_out/instruction_out/ret_PC to IF/ID; halted and sticky
//        ras_overflow/ras_underflow status.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            data_hazard,
  input  logic            PC_hazard,
  input  logic [PC_W-1:0] branch_target,
  input  logic            call,
  input  logic [11:0]     call_target,
  input  logic [PC_W-1:0] call_PC,
  input  logic            ret_control,
  input  logic            halt,
  input  logic [PC_W-1:0] imem_instr,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] PC_out,
  output logic [PC_W-1:0] instruction_out,
  output logic            ret_PC,
  output logic            halted,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  fetch_state_t    r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic            r_ret_pc, r_halted, r_ras_overflow, r_ras_underflow;

  logic            w_push, w_pop;
  logic [PC_W-1:0] w_push_data;
  logic [PC_W-1:0] w_ras_top;
  logic            w_ras_full, w_ras_empty, w_ras_ovf_evt, w_ras_unf_evt;

  assign w_push_data = PC_W'(call_PC + PC_W'(1));

  return_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk           (clk),
    .rst           (rst),
    .push          (w_push),
    .pop           (w_pop),
    .push_data     (w_push_data),
    .top           (w_ras_top),
    .full          (w_ras_full),
    .empty         (w_ras_empty),
    .overflow_evt  (w_ras_ovf_evt),
    .underflow_evt (w_ras_unf_evt)
  );

  // Next-PC priority and FSM; HALT is absorbing, halt overrides every redirect
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    if (r_state != HALT) begin
      w_state_nxt = RUN;
      if (halt) begin
        w_state_nxt = HALT;
      end else if (PC_hazard) begin
        w_pc_nxt = branch_target;
      end else if (call) begin
        w_pc_nxt = {call_PC[15:12], call_target};
        w_push   = 1'b1;
      end else if (ret_control && (r_state == RUN)) begin
        // A return with nothing on the stack freezes fetch at the current PC
        w_pop = 1'b1;
        if (w_ras_empty) begin
          w_state_nxt = HALT;
        end else begin
          w_pc_nxt    = w_ras_top;
          w_state_nxt = RET;
        end
      end else if (!data_hazard) begin
        w_pc_nxt = PC_W'(r_pc + PC_W'(1));
      end
    end
  end

  // State, PC and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= RUN;
      r_pc            <= RESET_PC;
      r_ret_pc        <= 1'b0;
      r_halted        <= 1'b0;
      r_ras_overflow  <= 1'b0;
      r_ras_underflow <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_pc            <= w_pc_nxt;
      r_ret_pc        <= (w_state_nxt == RET);
      r_halted        <= (w_state_nxt == HALT);
      r_ras_overflow  <= r_ras_overflow | w_ras_ovf_evt | (w_push & w_ras_full);
      r_ras_underflow <= r_ras_underflow | w_ras_unf_evt;
    end
  end

  assign imem_addr       = r_pc;
  assign PC_out          = r_pc;
  assign instruction_out = r_halted ? NO_OP : imem_instr;
  assign ret_PC          = r_ret_pc;
  assign halted          = r_halted;
  assign ras_overflow    = r_ras_overflow;
  assign ras_underflow   = r_ras_underflow;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_pc_fetch_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_hazard, PC_hazard, call, ret_control, halt;
  logic [15:0] branch_target, call_PC;
  logic [11:0] call_target;
  logic [15:0] imem_instr, imem_addr, PC_out, instruction_out;
  logic        ret_PC, halted, ras_overflow, ras_underflow;

  int checks   = 0;
  int failures = 0;

  pc_fetch_unit #(.RESET_PC(16'h0000), .RAS_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_hazard     (data_hazard),
    .PC_hazard       (PC_hazard),
    .branch_target   (branch_target),
    .call            (call),
    .call_target     (call_target),
    .call_PC         (call_PC),
    .ret_control     (ret_control),
    .halt            (halt),
    .imem_instr      (imem_instr),
    .imem_addr       (imem_addr),
    .PC_out          (PC_out),
    .instruction_out (instruction_out),
    .ret_PC          (ret_PC),
    .halted          (halted),
    .ras_overflow    (ras_overflow),
    .ras_underflow   (ras_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C3C;
  endfunction

  assign imem_instr = mem_f(imem_addr);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = running, 1 = cycle after a taken return, 2 = halted
  logic [15:0] m_pc = 16'h0000;
  int          m_mode = 0;
  logic        m_ovf = 1'b0, m_unf = 1'b0;
  logic [15:0] m_ras[$];
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 16'h0000; m_mode = 0; m_ovf = 1'b0; m_unf = 1'b0;
      m_ras.delete();
    end else if (m_mode != 2) begin
      int nm;
      nm = 0;
      if (halt) nm = 2;
      else if (PC_hazard) m_pc = branch_target;
      else if (call) begin
        m_ras.push_back(16'(call_PC + 16'd1));
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_pc = {call_PC[15:12], call_target};
      end else if (ret_control && m_mode == 0) begin
        if (m_ras.size() == 0) begin
          m_unf = 1'b1; nm = 2;
        end else begin
          m_pc = m_ras.pop_back(); nm = 1;
        end
      end else if (!data_hazard) m_pc = 16'(m_pc + 16'd1);
      m_mode = nm;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_out", PC_out, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("instr", instruction_out, (m_mode == 2) ? 16'hF000 : mem_f(m_pc));
      chk("ret_pc", 16'(ret_PC), 16'(m_mode == 1));
      chk("halted", 16'(halted), 16'(m_mode == 2));
      chk("ras_ovf", 16'(ras_overflow), 16'(m_ovf));
      chk("ras_unf", 16'(ras_underflow), 16'(m_unf));
    end
  end

  task automatic idle();
    data_hazard = 0; PC_hazard = 0; call = 0; ret_control = 0; halt = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; branch_target = '0; call_PC = '0; call_target = '0;
    idle();
    tick();
    chk_en = 1'b1;
    do_reset();

    // Free run from reset
    chk("reset_pc", PC_out, 16'h0000);
    chk("reset_halted", 16'(halted), 16'h0);
    tick(); chk("run1", PC_out, 16'h0001);
    tick(); chk("run2", PC_out, 16'h0002);
    tick(); chk("run3", PC_out, 16'h0003);
    chk("run_retpc", 16'(ret_PC), 16'h0);

    // Data hazard hold
    PC_hazard = 1; branch_target = 16'h0010;
    tick(); chk("branch", PC_out, 16'h0010);
    PC_hazard = 0; data_hazard = 1;
    tick(); chk("hold1", PC_out, 16'h0010);
    tick(); chk("hold2", PC_out, 16'h0010);
    data_hazard = 0;
    tick(); chk("after_hold", PC_out, 16'h0011);

    // Call then return
    call = 1; call_PC = 16'h1234; call_target = 12'h0AB;
    tick(); chk("call_pc", PC_out, 16'h10AB);
    call = 0;
    tick(); ret_control = 1;
    tick(); chk("ret_target", PC_out, 16'h1235);
    chk("ret_pulse", 16'(ret_PC), 16'h1);
    ret_control = 0;
    tick(); chk("ret_pulse_end", 16'(ret_PC), 16'h0);

    // Branch beats call; following return underflows
    PC_hazard = 1; branch_target = 16'h0200; call = 1; call_PC = 16'h5555; call_target = 12'h123;
    tick(); chk("branch_over_call", PC_out, 16'h0200);
    idle(); ret_control = 1;
    tick(); idle();
    chk("unf_flag", 16'(ras_underflow), 16'h1);
    chk("unf_halted", 16'(halted), 16'h1);
    chk("unf_instr", instruction_out, 16'hF000);
    chk("unf_pc_held", PC_out, 16'h0200);
    do_reset();
    chk("rst_unf_clear", 16'(ras_underflow), 16'h0);

    // Five nested calls into a four-deep stack
    for (int k = 1; k <= 5; k++) begin
      call = 1; call_PC = 16'(k * 16'h0100); call_target = 12'(k);
      tick();
    end
    idle();
    tick(); chk("ovf_flag", 16'(ras_overflow), 16'h1);
    for (int k = 5; k >= 2; k--) begin
      ret_control = 1; tick(); idle();
      chk("nested_ret", PC_out, 16'(k * 16'h0100 + 1));
      tick();
    end
    ret_control = 1; tick(); idle();
    chk("fifth_ret_halt", 16'(halted), 16'h1);
    do_reset();

    // PC wrap, then halt is absorbing until reset
    PC_hazard = 1; branch_target = 16'hFFFF;
    tick(); idle();
    tick(); chk("wrap", PC_out, 16'h0000);
    halt = 1;
    tick(); idle();
    chk("halt_flag", 16'(halted), 16'h1);
    chk("halt_pc", PC_out, 16'h0000);
    PC_hazard = 1; branch_target = 16'h0777; call = 1;
    tick(); tick(); idle();
    chk("halt_frozen", PC_out, 16'h0000);
    do_reset();
    chk("halt_rst_pc", PC_out, 16'h0000);
    chk("halt_rst_flag", 16'(halted), 16'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(99) < 2) || (halted && $urandom_range(3) == 0);
      PC_hazard     = ($urandom_range(99) < 10);
      call          = ($urandom_range(99) < 15);
      ret_control   = ($urandom_range(99) < 20);
      data_hazard   = ($urandom_range(99) < 20);
      halt          = ($urandom_range(999) < 5);
      branch_target = 16'($urandom);
      call_PC       = ($urandom_range(9) == 0) ? 16'hFFFF : 16'($urandom);
      call_target   = 12'($urandom);
      tick();
    end
    rst = 0; idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
